// File: rtl/alu_pkg.sv
// Shared definitions for the alu8 block: operation select codes,
// default datapath width and the status-flag bundle.
// Imported by alu8_if, alu8_core and alu8.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef struct packed {
    logic zero;
    logic negative;
    logic carry;
    logic overflow;
  } alu_flags_t;

  // Flag state presented while in reset: a cleared result reads as zero.
  localparam alu_flags_t FLAGS_RST = '{zero: 1'b1, negative: 1'b0, carry: 1'b0, overflow: 1'b0};

endpackage

// File: rtl/alu8_if.sv
// Operand/result bundle between the register file side and the ALU.
// Ports: in_valid/a/b/sel towards the ALU; out_valid/result/zero/negative/carry/overflow back.
// slave modport is the ALU side, master modport is the requester side.
interface alu8_if #(
  parameter int WIDTH = alu_pkg::ALU_WIDTH
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       sel;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             negative;
  logic             carry;
  logic             overflow;

  modport slave (
    input  in_valid, a, b, sel,
    output out_valid, result, zero, negative, carry, overflow
  );

  modport master (
    output in_valid, a, b, sel,
    input  out_valid, result, zero, negative, carry, overflow
  );
endinterface

// File: rtl/alu8_core.sv
// Combinational ALU core: ADD/SUB/AND/OR with zero/negative/carry/overflow flags.
// Latency: none (pure combinational). Backpressure: not applicable.
// Ports: a, b, sel in; result, flags out.
module alu8_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] result,
  output alu_flags_t       flags
);

  // One extra bit so that bit WIDTH carries the carry-out (ADD) or the
  // borrow (SUB: the zero-extended difference goes negative iff a < b).
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    diff   = {1'b0, a} - {1'b0, b};
    result = '0;
    flags  = '0;
    case (sel)
      ALU_ADD: begin
        result         = sum[WIDTH-1:0];
        flags.carry    = sum[WIDTH];
        flags.overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        result         = diff[WIDTH-1:0];
        flags.carry    = diff[WIDTH];
        flags.overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_AND: begin
        result = a & b;
      end
      default: begin
        result = a | b;
      end
    endcase
    flags.zero     = (result == '0);
    flags.negative = result[WIDTH-1];
  end

endmodule

// File: rtl/alu8.sv
// Registered 8-bit ALU: core result and flags captured on every valid operand pair.
// Latency: 1 cycle, one op per cycle; no backpressure (always accepts).
// Ports: clk, rst_n (async active-low), bus (alu8_if.slave) carrying operands and results.
module alu8
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input logic   clk,
  input logic   rst_n,
  alu8_if.slave bus
);

  logic [WIDTH-1:0] core_result;
  alu_flags_t       core_flags;

  logic             valid_q;
  logic [WIDTH-1:0] result_q;
  alu_flags_t       flags_q;

  alu8_core #(.WIDTH(WIDTH)) u_core (
    .a      (bus.a),
    .b      (bus.b),
    .sel    (bus.sel),
    .result (core_result),
    .flags  (core_flags)
  );

  // Result and flags only load on a valid op so that idle cycles leave
  // the last answer visible to the writeback stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      flags_q  <= FLAGS_RST;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        result_q <= core_result;
        flags_q  <= core_flags;
      end
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = flags_q.zero;
  assign bus.negative  = flags_q.negative;
  assign bus.carry     = flags_q.carry;
  assign bus.overflow  = flags_q.overflow;

endmodule

// File: tb/tb_alu8.sv
// Testbench for alu8: directed vectors, expected responses queued at issue time
// and popped by a monitor whenever out_valid is seen.
module tb_alu8;
  import alu_pkg::*;

  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       z;
    logic       n;
    logic       c;
    logic       v;
  } vec_t;

  // {out_valid, result, zero, negative, carry, overflow}
  typedef logic [12:0] obs_t;

  logic clk;
  logic rst_n;

  alu8_if #(.WIDTH(8)) bus ();

  alu8 #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  obs_t exp_q[$];
  obs_t last_exp;
  vec_t vecs[$];

  localparam obs_t RST_OBS = {1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};

  function automatic vec_t mk(input logic [1:0] sel, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] res, input logic z, input logic n,
                              input logic c, input logic v);
    vec_t t;
    t.sel = sel; t.a = a; t.b = b; t.res = res;
    t.z = z; t.n = n; t.c = c; t.v = v;
    return t;
  endfunction

  function automatic obs_t observe();
    return {bus.out_valid, bus.result, bus.zero, bus.negative, bus.carry, bus.overflow};
  endfunction

  task automatic check(input string name, input obs_t got, input obs_t want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got vld=%b res=%02h z=%b n=%b c=%b v=%b, want vld=%b res=%02h z=%b n=%b c=%b v=%b",
               name, got[12], got[11:4], got[3], got[2], got[1], got[0],
               want[12], want[11:4], want[3], want[2], want[1], want[0]);
    end
  endtask

  task automatic issue(input vec_t t);
    bus.in_valid = 1'b1;
    bus.a        = t.a;
    bus.b        = t.b;
    bus.sel      = t.sel;
    exp_q.push_back({1'b1, t.res, t.z, t.n, t.c, t.v});
  endtask

  task automatic idle(input logic [7:0] a, input logic [7:0] b);
    bus.in_valid = 1'b0;
    bus.a        = a;
    bus.b        = b;
    bus.sel      = ALU_ADD;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: samples on the falling edge, away from the capture edge.
  initial last_exp = RST_OBS;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      last_exp = RST_OBS;
      check("reset_state", observe(), RST_OBS);
    end else if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_valid: got out_valid=1 res=%02h, want no output", bus.result);
      end else begin
        last_exp = exp_q.pop_front();
        check("result", observe(), last_exp);
      end
    end else begin
      check("hold", observe(), {1'b0, last_exp[11:0]});
    end
  end

  initial begin
    vecs.push_back(mk(ALU_ADD, 8'd10,  8'd5,   8'd15,  1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(ALU_ADD, 8'd200, 8'd100, 8'd44,  1'b0, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(ALU_ADD, 8'd127, 8'd1,   8'd128, 1'b0, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(ALU_SUB, 8'd10,  8'd3,   8'd7,   1'b0, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(ALU_SUB, 8'd7,   8'd7,   8'd0,   1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(ALU_SUB, 8'd3,   8'd5,   8'hFE,  1'b0, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(ALU_SUB, 8'h80,  8'h01,  8'h7F,  1'b0, 1'b0, 1'b0, 1'b1));
    vecs.push_back(mk(ALU_AND, 8'hAA,  8'hCC,  8'h88,  1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(ALU_OR,  8'h0F,  8'hF0,  8'hFF,  1'b0, 1'b1, 1'b0, 1'b0));
    vecs.push_back(mk(ALU_AND, 8'hF0,  8'h0F,  8'h00,  1'b1, 1'b0, 1'b0, 1'b0));
    vecs.push_back(mk(ALU_ADD, 8'hFF,  8'h01,  8'h00,  1'b1, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(ALU_SUB, 8'h00,  8'h01,  8'hFF,  1'b0, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(ALU_ADD, 8'h80,  8'h80,  8'h00,  1'b1, 1'b0, 1'b1, 1'b1));

    rst_n = 1'b0;
    idle(8'h00, 8'h00);
    repeat (3) step();
    rst_n = 1'b1;

    // Back-to-back stream of every vector.
    foreach (vecs[i]) begin
      issue(vecs[i]);
      step();
    end

    // Idle cycles with changing operands: outputs must hold.
    idle(8'h33, 8'h44);
    step();
    idle(8'h5A, 8'hA5);
    step();

    // Valid ops interleaved with bubbles.
    issue(vecs[1]);
    step();
    idle(8'h12, 8'h34);
    step();
    issue(vecs[5]);
    step();
    idle(8'hFF, 8'hFF);
    step();

    // Reset mid-stream: result 0x80 is on the outputs, another op is pending.
    issue(vecs[2]);
    step();
    issue(vecs[7]);
    #5;
    rst_n = 1'b0;
    #1;
    check("async_reset", observe(), RST_OBS);
    step();
    idle(8'h00, 8'h00);
    step();
    rst_n = 1'b1;

    // First op after reset behaves normally.
    issue(vecs[0]);
    step();
    issue(vecs[8]);
    step();
    idle(8'h00, 8'h00);
    repeat (3) step();

    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d outstanding results, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu8.md
Name: alu8

Overview:
- 8-bit registered integer ALU with four operations: ADD, SUB, AND, OR.
- Produces the result plus zero/negative/carry/overflow status flags, one clock after a valid operand pair.
- Sits in the datapath between the register file and the writeback/flag register.
- A combinational core computes each operation; an output register stage presents result and flags.

Parameters:
- WIDTH, 8, operand and result width in bits (must be >= 2).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operands and sel are valid this cycle.
- a  input  WIDTH  operand A (unsigned / two's complement).
- b  input  WIDTH  operand B.
- sel  input  2  operation select: 00 ADD, 01 SUB, 10 AND, 11 OR.
- out_valid  output  1  result/flags updated this cycle.
- result  output  WIDTH  operation result.
- zero  output  1  result == 0.
- negative  output  1  result[WIDTH-1].
- carry  output  1  ADD: carry out; SUB: borrow (1 when a < b unsigned); logic ops: 0.
- overflow  output  1  signed overflow for ADD/SUB; logic ops: 0.

Behaviour:
- Interface: one clock domain; reset is asynchronous and active-low.
- Reset (rst_n=0, asynchronous assert, synchronous deassert at the clk edge):
  - result=0, zero=1, negative=0, carry=0, overflow=0, out_valid=0.
- Latency: exactly 1 cycle. Inputs sampled at rising clk with in_valid=1 appear on the outputs after that edge, together with out_valid=1.
- in_valid=0 at an edge: out_valid=0 next cycle; result and all flags hold their previous values.
- Throughput: one operation per cycle; back-to-back in_valid accepted; no backpressure.
- ADD:
  - result = (a+b) mod 2^WIDTH; carry = bit WIDTH of the (WIDTH+1)-bit sum.
  - overflow = (a[msb]==b[msb]) && (result[msb]!=a[msb]).
- SUB:
  - result = (a-b) mod 2^WIDTH (wraps, e.g. 3-5 = 0xFE); carry = 1 iff a < b unsigned.
  - overflow = (a[msb]!=b[msb]) && (result[msb]!=a[msb]).
- AND / OR: bitwise; carry=0, overflow=0.
- zero and negative are derived from the registered result for every operation.
- Reset asserted mid-operation: outputs clear immediately; the pending op is discarded. The first valid input after deassertion behaves normally.
- No X propagation: with all inputs known, all outputs are known at all times after reset.

Decomposition:
- Shared package alu_pkg:
  - sel encodings as localparams: ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_OR=2'b11.
  - default WIDTH constant.
  - flag-bundle struct {zero, negative, carry, overflow}.
- One sub-module, alu8_core: purely combinational; takes a, b, sel; returns result and flags.
- alu8 top: instantiates alu8_core and adds the valid/output register stage with async reset.

Test Plan:
- Reset: hold rst_n=0, then release -> result=0, zero=1, carry=0, overflow=0, negative=0, out_valid=0; assert rst_n=0 mid-stream -> outputs clear without waiting for clk.
- ADD: a=10, b=5, sel=00 -> next cycle result=15, zero=0, carry=0, out_valid=1. Also a=200, b=100 -> result=44, carry=1; a=127, b=1 -> result=128, overflow=1, negative=1.
- SUB: a=10, b=3 -> result=7, zero=0. a=7, b=7 -> result=0, zero=1, carry=0. a=3, b=5 -> result=0xFE, carry=1, negative=1. a=0x80, b=1 -> result=0x7F, overflow=1.
- Logic ops: AND a=0xAA, b=0xCC -> result=0x88, zero=0. OR a=0x0F, b=0xF0 -> result=0xFF, negative=1, carry=0, overflow=0. AND 0xF0 & 0x0F -> result=0, zero=1.
- Valid handling: back-to-back ops on consecutive cycles each produce their result one cycle later; drop in_valid for one cycle while changing a/b -> out_valid=0 and result/flags unchanged.
